// File: rtl/expansion_shiftreg_chain_if.sv
`default_nettype none
// ============================================================================
//  Module   : expansion_shiftreg_chain_if
//  Function : Register-map side bus of the shift-register chain expander:
//             run enable, output image, input image and frame status.
//  Revision : 1.0  initial release
// ============================================================================
interface expansion_shiftreg_chain_if #(
    parameter int WIDTH  = 8,
    parameter int CHAINS = 1
);
    logic                      enable;
    logic [CHAINS*WIDTH-1:0]   data_out;
    logic [CHAINS*WIDTH-1:0]   data_in;
    logic                      frame_done;
    logic                      busy;

    // Register map drives the image and enable, observes the status
    modport master (
        output enable,
        output data_out,
        input  data_in,
        input  frame_done,
        input  busy
    );

    // The expander consumes the image and reports status
    modport slave (
        input  enable,
        input  data_out,
        output data_in,
        output frame_done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/expansion_shiftreg_chain.sv
`default_nettype none
// ============================================================================
//  Module   : expansion_shiftreg_chain
//  Function : Drives CHAINS parallel daisy-chains of 74HC595 / 74HC165 with a
//             shared shift clock and load strobe. Frames are tear-free: the
//             output image is snapshotted at frame start and the input image
//             is committed atomically at frame end.
//  Revision : 1.0  initial release
// ============================================================================
module expansion_shiftreg_chain #(
    parameter int WIDTH     = 8,
    parameter int CHAINS    = 1,
    parameter int DIVIDER   = 100,
    parameter int MSB_FIRST = 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    expansion_shiftreg_chain_if.slave bus,
    output logic [CHAINS-1:0]         SHIFT_OUT,
    input  wire logic [CHAINS-1:0]    SHIFT_IN,
    output logic                      SHIFT_CLK,
    output logic                      SHIFT_LOAD
);

    localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int K_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] C_CNT_RELOAD = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam logic [K_W-1:0]   C_K_LAST     = K_W'(WIDTH - 1);
    localparam logic [K_W-1:0]   C_K_ONE      = K_W'(1);

    typedef enum logic [2:0] {
        S_PRIME = 3'd0,
        S_IDLE  = 3'd1,
        S_SETUP = 3'd2,
        S_HIGH  = 3'd3,
        S_LATCH = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [K_W-1:0]          r_k, w_k_nxt;
    logic                    r_prime_low, w_prime_low_nxt;
    logic                    r_sclk, w_sclk_nxt;
    logic                    r_sload, w_sload_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_frame_done;
    logic [CHAINS-1:0]       r_sout;
    logic [CHAINS*WIDTH-1:0] r_data_in;
    logic [WIDTH-1:0]        r_shadow_out [CHAINS];
    logic [WIDTH-1:0]        r_shadow_in  [CHAINS];

    logic                    w_tick;
    logic                    w_snapshot;
    logic                    w_shift;
    logic                    w_commit;
    logic [K_W-1:0]          w_pos;

    assign w_tick = (r_cnt == '0);
    // Bit position within each chain for the current bit index
    assign w_pos  = (MSB_FIRST != 0) ? (C_K_LAST - r_k) : r_k;

    // Next-state and pin decisions; everything moves only on a tick
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_prime_low_nxt = r_prime_low;
        w_sclk_nxt      = r_sclk;
        w_sload_nxt     = r_sload;
        w_busy_nxt      = r_busy;
        w_snapshot      = 1'b0;
        w_shift         = 1'b0;
        w_commit        = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_PRIME: begin
                    // Two ticks: strobe the '165 parallel load, then release
                    if (!r_prime_low) begin
                        w_sload_nxt     = 1'b0;
                        w_prime_low_nxt = 1'b1;
                    end else begin
                        w_sload_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.enable) begin
                        w_snapshot  = 1'b1;
                        w_k_nxt     = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SETUP;
                    end
                end
                S_SETUP: begin
                    w_sclk_nxt  = 1'b0;
                    w_shift     = 1'b1;
                    w_state_nxt = S_HIGH;
                end
                S_HIGH: begin
                    w_sclk_nxt = 1'b1;
                    if (r_k == C_K_LAST) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_k_nxt     = r_k + C_K_ONE;
                        w_state_nxt = S_SETUP;
                    end
                end
                S_LATCH: begin
                    w_sclk_nxt  = 1'b0;
                    w_sload_nxt = 1'b0;
                    w_state_nxt = S_HOLD;
                end
                S_HOLD: begin
                    w_sload_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    w_commit = 1'b1;
                    // Back-to-back frames skip IDLE entirely
                    if (bus.enable) begin
                        w_snapshot  = 1'b1;
                        w_k_nxt     = '0;
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_PRIME;
                end
            endcase
        end
    end

    // Control state, tick divider and shared pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_PRIME;
            r_cnt        <= C_CNT_RELOAD;
            r_k          <= '0;
            r_prime_low  <= 1'b0;
            r_sclk       <= 1'b0;
            r_sload      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_tick ? C_CNT_RELOAD : (r_cnt - C_CNT_ONE);
            r_k          <= w_k_nxt;
            r_prime_low  <= w_prime_low_nxt;
            r_sclk       <= w_sclk_nxt;
            r_sload      <= w_sload_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_commit;
        end
    end

    // Frame shadows: output snapshot and bit-wise input capture
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHAINS; c++) begin
            if (w_snapshot) begin
                r_shadow_out[c] <= bus.data_out[c*WIDTH +: WIDTH];
            end
            if (w_shift) begin
                r_shadow_in[c][w_pos] <= SHIFT_IN[c];
            end
        end
    end

    // Serial data pins and the atomically committed input image
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sout    <= '0;
            r_data_in <= '0;
        end else begin
            for (int c = 0; c < CHAINS; c++) begin
                if (w_shift) begin
                    r_sout[c] <= r_shadow_out[c][w_pos];
                end
                if (w_commit) begin
                    r_data_in[c*WIDTH +: WIDTH] <= r_shadow_in[c];
                end
            end
        end
    end

    assign bus.data_in    = r_data_in;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;
    assign SHIFT_OUT      = r_sout;
    assign SHIFT_CLK      = r_sclk;
    assign SHIFT_LOAD     = r_sload;

endmodule
`default_nettype wire

// File: tb/tb_expansion_shiftreg_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expansion_shiftreg_chain
//  Function : Self-checking bench for expansion_shiftreg_chain. Three
//             instances: A (W8,C1,D1,MSB), B (W4,C2,D1,LSB), C (W8,C1,D5,MSB),
//             each with bench '165 models and an expected-value scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_expansion_shiftreg_chain;

    localparam logic [7:0] PAR_A  = 8'h3C;
    localparam logic [3:0] PAR_B0 = 4'hA;
    localparam logic [3:0] PAR_B1 = 4'h6;
    localparam logic [7:0] PAR_C  = 8'h96;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instances ----------------
    expansion_shiftreg_chain_if #(.WIDTH(8), .CHAINS(1)) ifa ();
    expansion_shiftreg_chain_if #(.WIDTH(4), .CHAINS(2)) ifb ();
    expansion_shiftreg_chain_if #(.WIDTH(8), .CHAINS(1)) ifc ();

    logic [0:0] sout_a, sin_a, sout_c, sin_c;
    logic [1:0] sout_b, sin_b;
    logic       sclk_a, sload_a, sclk_b, sload_b, sclk_c, sload_c;

    expansion_shiftreg_chain #(.WIDTH(8), .CHAINS(1), .DIVIDER(1), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(rst_v[0]), .bus(ifa),
        .SHIFT_OUT(sout_a), .SHIFT_IN(sin_a), .SHIFT_CLK(sclk_a), .SHIFT_LOAD(sload_a));
    expansion_shiftreg_chain #(.WIDTH(4), .CHAINS(2), .DIVIDER(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset(rst_v[1]), .bus(ifb),
        .SHIFT_OUT(sout_b), .SHIFT_IN(sin_b), .SHIFT_CLK(sclk_b), .SHIFT_LOAD(sload_b));
    expansion_shiftreg_chain #(.WIDTH(8), .CHAINS(1), .DIVIDER(5), .MSB_FIRST(1)) dut_c (
        .clk(clk), .reset(rst_v[2]), .bus(ifc),
        .SHIFT_OUT(sout_c), .SHIFT_IN(sin_c), .SHIFT_CLK(sclk_c), .SHIFT_LOAD(sload_c));

    // ---------------- '165 models (async load, shift on rising clock) ----------------
    logic [7:0] sr_a, sr_c;
    logic [3:0] sr_b0, sr_b1;

    always @(posedge sclk_a or negedge sload_a)
        if (!sload_a) sr_a <= PAR_A; else sr_a <= {sr_a[6:0], 1'b0};
    always @(posedge sclk_c or negedge sload_c)
        if (!sload_c) sr_c <= PAR_C; else sr_c <= {sr_c[6:0], 1'b0};
    // LSB-first wiring: bit 0 emerges first
    always @(posedge sclk_b or negedge sload_b)
        if (!sload_b) begin sr_b0 <= PAR_B0; sr_b1 <= PAR_B1; end
        else begin sr_b0 <= {1'b0, sr_b0[3:1]}; sr_b1 <= {1'b0, sr_b1[3:1]}; end

    assign sin_a = sr_a[7];
    assign sin_c = sr_c[7];
    assign sin_b = {sr_b1[0], sr_b0[0]};

    // ---------------- scoreboard ----------------
    logic [1:0] qbit_a[$], qbit_b[$], qbit_c[$];
    logic [7:0] qin_a[$],  qin_b[$],  qin_c[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] img);
        for (int i = 7; i >= 0; i--) qbit_a.push_back({1'b0, img[i]});
        qin_a.push_back(PAR_A);
    endtask

    task automatic push_b(input logic [7:0] img);
        for (int k = 0; k < 4; k++) qbit_b.push_back({img[4+k], img[k]});
        qin_b.push_back({PAR_B1, PAR_B0});
    endtask

    task automatic push_c(input logic [7:0] img);
        for (int i = 7; i >= 0; i--) qbit_c.push_back({1'b0, img[i]});
        qin_c.push_back(PAR_C);
    endtask

    // ---------------- monitors (pop side) ----------------
    logic a_clk_q, a_load_q, a_fd_q;
    int   a_rises, a_first_rise, a_last_rise, a_load_fall, a_load_rise;
    always @(negedge clk) begin
        if (rst_v[0]) begin
            a_clk_q = 1'b0; a_load_q = 1'b1; a_fd_q = 1'b0; a_rises = 0;
        end else begin
            if (sclk_a && !a_clk_q) begin
                if (a_rises == 0) a_first_rise = cyc;
                a_rises++;
                a_last_rise = cyc;
                if (qbit_a.size() > 0) chk("A_bit", sout_a, qbit_a.pop_front());
                else                   chk("A_bit_unexpected", 32'(qbit_a.size()), 1);
            end
            if (!sload_a && a_load_q) a_load_fall = cyc;
            if (sload_a && !a_load_q) a_load_rise = cyc;
            if (ifa.frame_done) begin
                if (qin_a.size() > 0) chk("A_data_in", ifa.data_in, qin_a.pop_front());
                else                  chk("A_done_unexpected", 32'(qin_a.size()), 1);
                chk("A_fd_width", a_fd_q, 0);
                chk("A_rises", a_rises, 8);
                chk("A_done_latency", cyc - a_first_rise, 17);
                chk("A_latch_gap", a_load_fall - a_last_rise, 1);
                chk("A_load_low", a_load_rise - a_load_fall, 1);
                a_rises = 0;
            end
            a_clk_q = sclk_a; a_load_q = sload_a; a_fd_q = ifa.frame_done;
        end
    end

    logic b_clk_q, b_fd_q;
    int   b_rises;
    always @(negedge clk) begin
        if (rst_v[1]) begin
            b_clk_q = 1'b0; b_fd_q = 1'b0; b_rises = 0;
        end else begin
            if (sclk_b && !b_clk_q) begin
                b_rises++;
                if (qbit_b.size() > 0) chk("B_bits", sout_b, qbit_b.pop_front());
                else                   chk("B_bit_unexpected", 32'(qbit_b.size()), 1);
            end
            if (ifb.frame_done) begin
                if (qin_b.size() > 0) chk("B_data_in", ifb.data_in, qin_b.pop_front());
                else                  chk("B_done_unexpected", 32'(qin_b.size()), 1);
                chk("B_fd_width", b_fd_q, 0);
                chk("B_rises", b_rises, 4);
                b_rises = 0;
            end
            b_clk_q = sclk_b; b_fd_q = ifb.frame_done;
        end
    end

    logic c_clk_q, c_load_q, c_fd_q, c_have_edge;
    int   c_rises, c_first_rise, c_last_rise, c_load_fall, c_load_rise, c_last_edge;
    always @(negedge clk) begin
        if (rst_v[2]) begin
            c_clk_q = 1'b0; c_load_q = 1'b1; c_fd_q = 1'b0; c_rises = 0; c_have_edge = 1'b0;
        end else begin
            if ((sclk_c != c_clk_q) || (sload_c != c_load_q)) begin
                if (c_have_edge) chk("C_edge_align", (cyc - c_last_edge) % 5, 0);
                c_have_edge = 1'b1;
                c_last_edge = cyc;
            end
            if (sclk_c && !c_clk_q) begin
                if (c_rises == 0) c_first_rise = cyc;
                c_rises++;
                c_last_rise = cyc;
                if (qbit_c.size() > 0) chk("C_bit", sout_c, qbit_c.pop_front());
                else                   chk("C_bit_unexpected", 32'(qbit_c.size()), 1);
            end
            if (!sload_c && c_load_q) c_load_fall = cyc;
            if (sload_c && !c_load_q) c_load_rise = cyc;
            if (ifc.frame_done) begin
                if (qin_c.size() > 0) chk("C_data_in", ifc.data_in, qin_c.pop_front());
                else                  chk("C_done_unexpected", 32'(qin_c.size()), 1);
                chk("C_fd_width", c_fd_q, 0);
                chk("C_done_latency", cyc - c_first_rise, 85);
                chk("C_latch_gap", c_load_fall - c_last_rise, 5);
                chk("C_load_low", c_load_rise - c_load_fall, 5);
                c_rises = 0;
            end
            c_clk_q = sclk_c; c_load_q = sload_c; c_fd_q = ifc.frame_done;
        end
    end

    // ---------------- bounded waits ----------------
    function automatic logic fd_of(input int u);
        case (u)
            0:       return ifa.frame_done;
            1:       return ifb.frame_done;
            default: return ifc.frame_done;
        endcase
    endfunction

    function automatic logic busy_of(input int u);
        case (u)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    task automatic wait_fd(input int u, input int budget, input string tag);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!fd_of(u) && n < budget);
        chk(tag, fd_of(u), 1);
    endtask

    task automatic wait_busy(input int u, input int budget, input string tag);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy_of(u) && n < budget);
        chk(tag, busy_of(u), 1);
    endtask

    // ---------------- directed stimulus ----------------
    int   t0, n, t;
    logic pq;
    initial begin
        rst_v        = 3'b111;
        ifa.enable   = 1'b0; ifa.data_out = 8'h00;
        ifb.enable   = 1'b0; ifb.data_out = 8'h00;
        ifc.enable   = 1'b0; ifc.data_out = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("A_rst_shift_out", sout_a, 0);
        chk("A_rst_shift_clk", sclk_a, 0);
        chk("A_rst_shift_load", sload_a, 1);
        chk("A_rst_data_in", ifa.data_in, 0);
        chk("A_rst_frame_done", ifa.frame_done, 0);
        chk("A_rst_busy", ifa.busy, 0);
        chk("C_rst_shift_load", sload_c, 1);

        // A: first frame after reset, 8'hA5, PRIME makes data_in valid
        ifa.data_out = 8'hA5;
        push_a(8'hA5);
        rst_v[0] = 1'b0;
        @(negedge clk); chk("A_prime_load_low", sload_a, 0);
        @(negedge clk); chk("A_prime_load_high", sload_a, 1);
        ifa.enable = 1'b1;
        wait_busy(0, 20, "A_busy_rise_timeout");
        ifa.enable = 1'b0;
        wait_fd(0, 60, "A_frame1_timeout");
        chk("A_busy_after_done", ifa.busy, 0);

        // A: data_out changes mid-frame; back-to-back period 19 clks
        ifa.data_out = 8'hFF;
        push_a(8'hFF);
        ifa.enable = 1'b1;
        wait_busy(0, 20, "A_busy_ff_timeout");
        repeat (5) @(negedge clk);
        ifa.data_out = 8'h00;
        push_a(8'h00);
        wait_fd(0, 60, "A_frame_ff_timeout");
        t0 = cyc;
        ifa.enable = 1'b0;
        wait_fd(0, 60, "A_frame_00_timeout");
        chk("A_period", cyc - t0, 19);
        repeat (3) @(negedge clk);
        chk("A_idle_busy", ifa.busy, 0);
        chk("A_idle_shift_clk", sclk_a, 0);

        // A: reset during HIGH of bit 3, then PRIME again and a full frame
        ifa.data_out = 8'hA5;
        push_a(8'hA5);
        ifa.enable = 1'b1;
        n = 0; t = 0; pq = 1'b0;
        while (n < 4 && t < 100) begin
            @(negedge clk); t++;
            if (sclk_a && !pq) n++;
            pq = sclk_a;
        end
        chk("A_reach_bit3", n, 4);
        rst_v[0] = 1'b1;
        @(negedge clk);
        chk("A_midrst_shift_clk", sclk_a, 0);
        chk("A_midrst_shift_load", sload_a, 1);
        chk("A_midrst_data_in", ifa.data_in, 0);
        chk("A_midrst_busy", ifa.busy, 0);
        qbit_a.delete();
        qin_a.delete();
        @(negedge clk);
        push_a(8'hA5);
        rst_v[0] = 1'b0;
        @(negedge clk); chk("A_reprime_load_low", sload_a, 0);
        @(negedge clk); chk("A_reprime_load_high", sload_a, 1);
        wait_busy(0, 20, "A_busy_rerun_timeout");
        ifa.enable = 1'b0;
        wait_fd(0, 60, "A_frame_rerun_timeout");

        // B: two chains, LSB first
        rst_v[1] = 1'b0;
        ifb.data_out = 8'h81;
        push_b(8'h81);
        repeat (2) @(negedge clk);
        ifb.enable = 1'b1;
        wait_busy(1, 20, "B_busy_timeout");
        ifb.enable = 1'b0;
        wait_fd(1, 60, "B_frame1_timeout");
        ifb.data_out = 8'h5E;
        push_b(8'h5E);
        ifb.enable = 1'b1;
        wait_busy(1, 20, "B_busy2_timeout");
        ifb.enable = 1'b0;
        wait_fd(1, 60, "B_frame2_timeout");
        chk("B_busy_after_done", ifb.busy, 0);

        // C: DIVIDER=5, three back-to-back frames, period 95 clks
        rst_v[2] = 1'b0;
        ifc.data_out = 8'hC3;
        push_c(8'hC3); push_c(8'hC3); push_c(8'hC3);
        ifc.enable = 1'b1;
        wait_fd(2, 300, "C_frame1_timeout");
        t0 = cyc;
        wait_fd(2, 300, "C_frame2_timeout");
        chk("C_period", cyc - t0, 95);
        t0 = cyc;
        ifc.enable = 1'b0;
        wait_fd(2, 300, "C_frame3_timeout");
        chk("C_period2", cyc - t0, 95);
        repeat (12) @(negedge clk);
        chk("C_idle_busy", ifc.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
